// File: rtl/aes_dec_loader.sv
// Word-stream loader and sequencer for a multicycle AES-256 decryption core.
// Define AES_DEC_LOADER_CBC_EN to add CBC chaining (16-word new-key blocks carrying an IV).
module aes_dec_loader #(
  parameter int LATENCY_P = 29
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [31:0]  word_i,
  input  logic         word_v_i,
  input  logic         new_key_i,
  output logic         word_ready_o,
  output logic [255:0] key_o,
  output logic [127:0] ciphertext_o,
  output logic         core_reset_o,
  input  logic [127:0] plaintext_i,
  output logic [127:0] plaintext_o,
  output logic         plaintext_v_o,
  input  logic         plaintext_yumi_i
);

`ifdef AES_DEC_LOADER_CBC_EN
  localparam logic [3:0] NK_LAST_LP = 4'd15;
`else
  localparam logic [3:0] NK_LAST_LP = 4'd11;
`endif
  localparam logic [7:0] LAT_LAST_LP = 8'(LATENCY_P - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_LAUNCH,
    S_WAIT,
    S_OUTPUT
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   word_cnt_q, word_cnt_d;
  logic [7:0]   lat_cnt_q, lat_cnt_d;
  logic         mode_q, mode_d;
  logic [255:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] pt_q, pt_d;
`ifdef AES_DEC_LOADER_CBC_EN
  logic [127:0] chain_q, chain_d;
`endif

  logic         blk_new;
  logic [3:0]   last_idx;
  logic [2:0]   key_slot;
  logic [1:0]   ct_slot;

  // Words land MSB first, so the slot index is the inverted low bits of the word count.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    mode_d     = mode_q;
    key_d      = key_q;
    ct_d       = ct_q;
    pt_d       = pt_q;
`ifdef AES_DEC_LOADER_CBC_EN
    chain_d    = chain_q;
`endif
    blk_new  = (word_cnt_q == 4'd0) ? new_key_i : mode_q;
    last_idx = blk_new ? NK_LAST_LP : 4'd3;
    key_slot = ~word_cnt_q[2:0];
    ct_slot  = ~word_cnt_q[1:0];

    unique case (state_q)
      S_COLLECT: begin
        if (word_v_i) begin
          if (word_cnt_q == 4'd0) mode_d = new_key_i;
          if (!blk_new) ct_d[{ct_slot, 5'd0} +: 32] = word_i;
          else if (!word_cnt_q[3]) key_d[{key_slot, 5'd0} +: 32] = word_i;
`ifdef AES_DEC_LOADER_CBC_EN
          else if (!word_cnt_q[2]) chain_d[{ct_slot, 5'd0} +: 32] = word_i;
`endif
          else ct_d[{ct_slot, 5'd0} +: 32] = word_i;
          if (word_cnt_q == last_idx) begin
            word_cnt_d = 4'd0;
            state_d    = S_LAUNCH;
          end else begin
            word_cnt_d = word_cnt_q + 4'd1;
          end
        end
      end
      S_LAUNCH: begin
        lat_cnt_d = 8'd0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST_LP) begin
`ifdef AES_DEC_LOADER_CBC_EN
          pt_d    = plaintext_i ^ chain_q;
          chain_d = ct_q;
`else
          pt_d    = plaintext_i;
`endif
          lat_cnt_d = 8'd0;
          state_d   = S_OUTPUT;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      S_OUTPUT: begin
        if (plaintext_yumi_i) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_COLLECT;
      word_cnt_q <= 4'd0;
      lat_cnt_q  <= 8'd0;
      mode_q     <= 1'b0;
      key_q      <= '0;
      ct_q       <= '0;
      pt_q       <= '0;
`ifdef AES_DEC_LOADER_CBC_EN
      chain_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      ct_q       <= ct_d;
      pt_q       <= pt_d;
`ifdef AES_DEC_LOADER_CBC_EN
      chain_q    <= chain_d;
`endif
    end
  end

  // The core only runs while its reset is released, which happens solely in WAIT.
  assign word_ready_o  = (state_q == S_COLLECT);
  assign core_reset_o  = (state_q != S_WAIT);
  assign plaintext_v_o = (state_q == S_OUTPUT);
  assign key_o         = key_q;
  assign ciphertext_o  = ct_q;
  assign plaintext_o   = pt_q;

endmodule

// File: tb/tb_aes_dec_loader.sv
// Self-checking bench for aes_dec_loader: a stand-in core answers only on the exact
// cycle its reset has been released for LAT cycles; a block-level model predicts plaintext.
module tb_aes_dec_loader;

  localparam int LAT = 29;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_IV  = 128'h0f0e0d0c0b0a09080706050403020100;

  logic         clk;
  logic         reset;
  logic [31:0]  word;
  logic         word_v;
  logic         new_key;
  logic         word_ready;
  logic [255:0] key_out;
  logic [127:0] ct_out;
  logic         core_reset;
  logic [127:0] pt_in;
  logic [127:0] pt_out;
  logic         pt_v;
  logic         yumi;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_run = 0;
  int last_run = 0;
  int t_last = 0;

  logic [255:0] model_key;
  logic [127:0] model_chain;
  logic [127:0] model_ct;
  logic [127:0] model_exp;

  aes_dec_loader #(.LATENCY_P(LAT)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .word_i           (word),
    .word_v_i         (word_v),
    .new_key_i        (new_key),
    .word_ready_o     (word_ready),
    .key_o            (key_out),
    .ciphertext_o     (ct_out),
    .core_reset_o     (core_reset),
    .plaintext_i      (pt_in),
    .plaintext_o      (pt_out),
    .plaintext_v_o    (pt_v),
    .plaintext_yumi_i (yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in decryption: the FIPS-197 vector is honoured, any other pair maps through a fixed mix.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return c ^ k[255:128] ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // The core output is only meaningful on the LAT-th cycle of released reset; otherwise garbage.
  always @(negedge clk) begin
    if (core_reset === 1'b0) begin
      low_run = low_run + 1;
    end else begin
      if (low_run != 0) last_run = low_run;
      low_run = 0;
    end
    if (low_run == LAT) pt_in = core_fn(key_out, ct_out);
    else pt_in = {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    word_v = 1'b0;
    yumi   = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    model_key   = '0;
    model_chain = '0;
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_key"}, 256'(key_out), 256'd0);
    chk({tag, "_ct"}, 256'(ct_out), 256'd0);
    chk({tag, "_pt"}, 256'(pt_out), 256'd0);
    chk({tag, "_pt_v"}, 256'(pt_v), 256'd0);
    chk({tag, "_core_reset"}, 256'(core_reset), 256'd1);
    chk({tag, "_ready"}, 256'(word_ready), 256'd1);
  endtask

  // t_last records the edge on which the word was taken; the cycle it was offered ends there.
  task automatic sendWord(input logic [31:0] w, input logic nk, input bit gap);
    int budget;
    if (gap) begin
      word_v = 1'b0;
      word   = $urandom;
      repeat ($urandom_range(1, 3)) tick();
    end
    word    = w;
    word_v  = 1'b1;
    new_key = nk;
    budget  = 0;
    while (word_ready !== 1'b1 && budget < 1000) begin
      tick();
      budget++;
    end
    if (word_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("[TB] FAIL word_ready_timeout observed=%0b expected=1", word_ready);
    end
    @(posedge clk);
    #1;
    t_last  = cyc;
    word_v  = 1'b0;
    word    = $urandom;
    new_key = 1'($urandom);
  endtask

  // Sends up to 'limit' words of a block; only a complete block advances the reference model.
  task automatic applyStimulus(input logic nk, input logic [255:0] k, input logic [127:0] c,
                               input logic [127:0] iv, input bit gap, input int limit);
    logic [31:0] words[$];
    if (nk) begin
      for (int i = 0; i < 8; i++) words.push_back(k[(7 - i) * 32 +: 32]);
`ifdef AES_DEC_LOADER_CBC_EN
      for (int i = 0; i < 4; i++) words.push_back(iv[(3 - i) * 32 +: 32]);
`endif
    end
    for (int i = 0; i < 4; i++) words.push_back(c[(3 - i) * 32 +: 32]);
    for (int i = 0; i < words.size() && i < limit; i++)
      sendWord(words[i], (i == 0) ? nk : 1'($urandom), gap);
    if (limit >= words.size()) begin
      if (nk) begin
        model_key   = k;
        model_chain = iv;
      end
      model_ct  = c;
      model_exp = core_fn(model_key, c);
`ifdef AES_DEC_LOADER_CBC_EN
      model_exp   = model_exp ^ model_chain;
      model_chain = c;
`endif
    end
  endtask

  // Plaintext must appear LAT+1 edges after the accepting edge (cycle T+LAT+2), then obey yumi.
  task automatic checkOutput(input string tag, input int hold);
    int budget;
    budget = 0;
    while (pt_v !== 1'b1 && budget < LAT + 40) begin
      word_v = 1'($urandom);
      word   = $urandom;
      tick();
      budget++;
    end
    word_v = 1'b0;
    if (pt_v !== 1'b1) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_timeout observed=%0b expected=1", tag, pt_v);
      return;
    end
    chk({tag, "_latency"}, 256'(cyc - t_last), 256'(LAT + 1));
    chk({tag, "_pt"}, 256'(pt_out), 256'(model_exp));
    chk({tag, "_key"}, key_out, model_key);
    chk({tag, "_ct"}, 256'(ct_out), 256'(model_ct));
    for (int i = 0; i < hold; i++) begin
      word_v  = 1'b1;
      word    = $urandom;
      new_key = 1'($urandom);
      tick();
      chk({tag, "_hold_v"}, 256'(pt_v), 256'd1);
      chk({tag, "_hold_pt"}, 256'(pt_out), 256'(model_exp));
      chk({tag, "_hold_ready"}, 256'(word_ready), 256'd0);
    end
    word_v = 1'b0;
    yumi   = 1'b1;
    tick();
    yumi   = 1'b0;
    chk({tag, "_ready_after_yumi"}, 256'(word_ready), 256'd1);
    chk({tag, "_v_after_yumi"}, 256'(pt_v), 256'd0);
    chk({tag, "_pt_kept"}, 256'(pt_out), 256'(model_exp));
    chk({tag, "_core_low_cycles"}, 256'(last_run), 256'(LAT));
  endtask

  initial begin
    logic [255:0] rk;
    logic [127:0] rc;
    logic [127:0] riv;
    reset = 1'b1; word = '0; word_v = 1'b0; new_key = 1'b0; yumi = 1'b0;
    model_key = '0; model_chain = '0; model_ct = '0; model_exp = '0;
    repeat (2) tick();
    doReset();
    checkReset("reset");

    // Reuse before any key load decrypts under an all-zero key.
    rc = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, '0, rc, '0, 1'b0, 99);
    checkOutput("reuse_first", 0);

    applyStimulus(1'b1, FIPS_KEY, FIPS_CT, FIPS_IV, 1'b0, 99);
    checkOutput("fips", 0);
    applyStimulus(1'b0, '0, FIPS_CT, '0, 1'b0, 99);
    checkOutput("fips_reuse_bp", 10);
    applyStimulus(1'b1, FIPS_KEY, FIPS_CT, FIPS_IV, 1'b1, 99);
    checkOutput("fips_gapped", 0);

    applyStimulus(1'b1, FIPS_KEY, FIPS_CT, FIPS_IV, 1'b0, 6);
    doReset();
    checkReset("reset_collect");
    applyStimulus(1'b1, FIPS_KEY, FIPS_CT, FIPS_IV, 1'b0, 99);
    checkOutput("fips_after_collect_reset", 0);

    applyStimulus(1'b1, FIPS_KEY, FIPS_CT, FIPS_IV, 1'b0, 99);
    repeat (5) tick();
    doReset();
    checkReset("reset_wait");
    applyStimulus(1'b1, FIPS_KEY, FIPS_CT, FIPS_IV, 1'b1, 99);
    checkOutput("fips_after_wait_reset", 0);

    for (int n = 0; n < 6; n++) begin
      rk = '0;
      for (int j = 0; j < 8; j++) rk = {rk[223:0], 32'($urandom)};
      rc  = {$urandom, $urandom, $urandom, $urandom};
      riv = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus((n == 0) ? 1'b1 : 1'($urandom), rk, rc, riv, 1'($urandom), 99);
      checkOutput("random", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
